// File: rtl/alu_seq_core_if.sv
// Handshake and result bus for alu_seq_core.
// The master drives the request and operands; the slave (the ALU core)
// returns status, result and flags.
interface alu_seq_core_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             fi;
   logic             eo;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] bus_out;
   logic [WIDTH-1:0] result_hi;
   logic             cf;
   logic             zf;
   logic             nf;
   logic             vf;

   modport master (
      output start, op, a, b, fi, eo,
      input  busy, done, bus_out, result_hi, cf, zf, nf, vf
   );

   modport slave (
      input  start, op, a, b, fi, eo,
      output busy, done, bus_out, result_hi, cf, zf, nf, vf
   );
endinterface

// File: rtl/alu_seq_core.sv
// Registered ALU core with a start/busy/done handshake.
// Single-cycle ops complete at the start edge; MUL runs an LSB-first
// shift-add over WIDTH cycles. Result and flags are held in registers,
// and the result reaches the shared bus only while eo is high.
module alu_seq_core #(
   parameter int WIDTH = 8
) (
   input logic          clk,
   input logic          rst_n,
   alu_seq_core_if.slave alu_if
);
   localparam int CNT_W = $clog2(WIDTH) + 1;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_SHR = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   typedef enum logic {S_IDLE, S_MUL} state_t;

   state_t             r_state;
   logic               r_busy;
   logic               r_done;
   logic [WIDTH-1:0]   r_result;
   logic [WIDTH-1:0]   r_result_hi;
   logic               r_cf, r_zf, r_nf, r_vf;
   logic [CNT_W-1:0]   r_cnt;
   logic [2*WIDTH-1:0] r_acc;
   logic [2*WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic               r_fi;

   logic [WIDTH:0]     w_sum;
   logic [WIDTH-1:0]   w_res;
   logic               w_cf;
   logic               w_vf;
   logic [2*WIDTH-1:0] w_acc_next;
   logic               w_last;

   // Single-cycle operation result and carry/overflow for the current request
   always_comb begin
      w_sum = '0;
      w_res = '0;
      w_cf  = 1'b0;
      w_vf  = 1'b0;
      case (alu_if.op)
         OP_ADD: begin
            w_sum = {1'b0, alu_if.a} + {1'b0, alu_if.b};
            w_res = w_sum[WIDTH-1:0];
            w_cf  = w_sum[WIDTH];
            w_vf  = (alu_if.a[WIDTH-1] == alu_if.b[WIDTH-1]) &&
                    (w_res[WIDTH-1] != alu_if.a[WIDTH-1]);
         end
         OP_SUB: begin
            // Two's-complement subtract; carry-out of 1 means no borrow.
            w_sum = {1'b0, alu_if.a} + {1'b0, ~alu_if.b} + (WIDTH+1)'(1);
            w_res = w_sum[WIDTH-1:0];
            w_cf  = w_sum[WIDTH];
            w_vf  = (alu_if.a[WIDTH-1] != alu_if.b[WIDTH-1]) &&
                    (w_res[WIDTH-1] != alu_if.a[WIDTH-1]);
         end
         OP_AND: w_res = alu_if.a & alu_if.b;
         OP_OR:  w_res = alu_if.a | alu_if.b;
         OP_XOR: w_res = alu_if.a ^ alu_if.b;
         OP_SHL: begin
            w_res = {alu_if.a[WIDTH-2:0], 1'b0};
            w_cf  = alu_if.a[WIDTH-1];
         end
         OP_SHR: begin
            w_res = {1'b0, alu_if.a[WIDTH-1:1]};
            w_cf  = alu_if.a[0];
         end
         default: ;
      endcase
   end

   // One shift-add step: add the shifted multiplicand when the current multiplier LSB is set
   always_comb begin
      w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
      w_last     = (r_cnt == CNT_W'(WIDTH - 1));
   end

   // Control FSM with registered result, flags and handshake outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_result    <= '0;
         r_result_hi <= '0;
         r_cf        <= 1'b0;
         r_zf        <= 1'b0;
         r_nf        <= 1'b0;
         r_vf        <= 1'b0;
         r_cnt       <= '0;
         r_acc       <= '0;
         r_mcand     <= '0;
         r_mplier    <= '0;
         r_fi        <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (alu_if.start) begin
                  if (alu_if.op == OP_MUL) begin
                     r_acc    <= '0;
                     r_mcand  <= {{WIDTH{1'b0}}, alu_if.a};
                     r_mplier <= alu_if.b;
                     r_fi     <= alu_if.fi;
                     r_cnt    <= '0;
                     r_busy   <= 1'b1;
                     r_state  <= S_MUL;
                  end else begin
                     r_result    <= w_res;
                     r_result_hi <= '0;
                     r_done      <= 1'b1;
                     if (alu_if.fi) begin
                        r_cf <= w_cf;
                        r_zf <= (w_res == '0);
                        r_nf <= w_res[WIDTH-1];
                        r_vf <= w_vf;
                     end
                  end
               end
            end
            S_MUL: begin
               r_acc    <= w_acc_next;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + CNT_W'(1);
               if (w_last) begin
                  r_result    <= w_acc_next[WIDTH-1:0];
                  r_result_hi <= w_acc_next[2*WIDTH-1:WIDTH];
                  r_done      <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= S_IDLE;
                  if (r_fi) begin
                     r_cf <= |w_acc_next[2*WIDTH-1:WIDTH];
                     r_zf <= (w_acc_next == '0);
                     r_nf <= w_acc_next[WIDTH-1];
                     r_vf <= 1'b0;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign alu_if.busy      = r_busy;
   assign alu_if.done      = r_done;
   assign alu_if.bus_out   = alu_if.eo ? r_result : '0;
   assign alu_if.result_hi = r_result_hi;
   assign alu_if.cf        = r_cf;
   assign alu_if.zf        = r_zf;
   assign alu_if.nf        = r_nf;
   assign alu_if.vf        = r_vf;
endmodule

// File: tb/tb_alu_seq_core.sv
// Directed testbench for alu_seq_core (WIDTH=8).
module tb_alu_seq_core;
   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_SHR = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   alu_seq_core_if #(.WIDTH(8)) u_if ();

   alu_seq_core #(.WIDTH(8)) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .alu_if (u_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // flags packed as {cf,zf,nf,vf}
   task automatic chk_flags(input string tag, input logic [3:0] exp);
      chk(tag, {12'd0, u_if.cf, u_if.zf, u_if.nf, u_if.vf}, {12'd0, exp});
   endtask

   task automatic do_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic fi);
      u_if.op    = op;
      u_if.a     = a;
      u_if.b     = b;
      u_if.fi    = fi;
      u_if.start = 1'b1;
      @(posedge clk);
      #1;
      u_if.start = 1'b0;
   endtask

   initial begin
      int n_busy;
      int n_cyc;
      int n_done;
      bit seen;
      n_tests    = 0;
      n_fail     = 0;
      rst_n      = 1'b0;
      u_if.start = 1'b0;
      u_if.op    = OP_ADD;
      u_if.a     = 8'h00;
      u_if.b     = 8'h00;
      u_if.fi    = 1'b0;
      u_if.eo    = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", {15'd0, u_if.busy}, 16'd0);
      chk("rst_done", {15'd0, u_if.done}, 16'd0);
      chk("rst_result", {8'd0, u_if.bus_out}, 16'h0000);
      chk("rst_result_hi", {8'd0, u_if.result_hi}, 16'h0000);
      chk_flags("rst_flags", 4'b0000);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // ADD with carry-out and zero result
      do_op(OP_ADD, 8'hFF, 8'h01, 1'b1);
      chk("add1_done", {15'd0, u_if.done}, 16'd1);
      chk("add1_res", {8'd0, u_if.bus_out}, 16'h0000);
      chk_flags("add1_flags", 4'b1100);
      @(posedge clk);
      #1;
      chk("add1_done_pulse", {15'd0, u_if.done}, 16'd0);

      // ADD with signed overflow
      do_op(OP_ADD, 8'h7F, 8'h01, 1'b1);
      chk("add2_res", {8'd0, u_if.bus_out}, 16'h0080);
      chk_flags("add2_flags", 4'b0011);

      // SUB without and with borrow, then with flag load disabled
      do_op(OP_SUB, 8'h05, 8'h03, 1'b1);
      chk("sub1_res", {8'd0, u_if.bus_out}, 16'h0002);
      chk_flags("sub1_flags", 4'b1000);
      do_op(OP_SUB, 8'h03, 8'h05, 1'b1);
      chk("sub2_res", {8'd0, u_if.bus_out}, 16'h00FE);
      chk_flags("sub2_flags", 4'b0010);
      do_op(OP_SUB, 8'h05, 8'h03, 1'b0);
      chk("sub3_res", {8'd0, u_if.bus_out}, 16'h0002);
      chk_flags("sub3_flags_hold", 4'b0010);

      // Back-to-back starts: AND then OR on consecutive edges
      u_if.op = OP_AND; u_if.a = 8'hF0; u_if.b = 8'h3C; u_if.fi = 1'b1; u_if.start = 1'b1;
      @(posedge clk);
      #1;
      chk("b2b_and_done", {15'd0, u_if.done}, 16'd1);
      chk("b2b_and_res", {8'd0, u_if.bus_out}, 16'h0030);
      u_if.op = OP_OR; u_if.a = 8'h0F; u_if.b = 8'hF0;
      @(posedge clk);
      #1;
      u_if.start = 1'b0;
      chk("b2b_or_done", {15'd0, u_if.done}, 16'd1);
      chk("b2b_or_res", {8'd0, u_if.bus_out}, 16'h00FF);
      chk_flags("b2b_or_flags", 4'b0010);

      // Shifts and XOR
      do_op(OP_SHL, 8'h81, 8'h00, 1'b1);
      chk("shl_res", {8'd0, u_if.bus_out}, 16'h0002);
      chk_flags("shl_flags", 4'b1000);
      do_op(OP_SHR, 8'h01, 8'hFF, 1'b1);
      chk("shr_res", {8'd0, u_if.bus_out}, 16'h0000);
      chk_flags("shr_flags", 4'b1100);
      do_op(OP_XOR, 8'hAA, 8'hAA, 1'b1);
      chk("xor_res", {8'd0, u_if.bus_out}, 16'h0000);
      chk_flags("xor_flags", 4'b0100);

      // MUL 0xFF*0xFF with an ignored start while busy
      do_op(OP_MUL, 8'hFF, 8'hFF, 1'b1);
      chk("mul_busy_start", {15'd0, u_if.busy}, 16'd1);
      chk("mul_done_early", {15'd0, u_if.done}, 16'd0);
      n_busy = 1;
      n_cyc  = 0;
      seen   = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (i == 2) begin
            u_if.op = OP_ADD; u_if.a = 8'h02; u_if.b = 8'h02; u_if.fi = 1'b0;
            u_if.start = 1'b1;
         end else begin
            u_if.start = 1'b0;
         end
         @(posedge clk);
         #1;
         n_cyc++;
         if (u_if.done) begin
            seen = 1'b1;
            break;
         end
         if (u_if.busy) n_busy++;
      end
      u_if.start = 1'b0;
      chk("mul_done_seen", {15'd0, seen}, 16'd1);
      chk("mul_latency", n_cyc[15:0], 16'd8);
      chk("mul_busy_cycles", n_busy[15:0], 16'd8);
      chk("mul_busy_at_done", {15'd0, u_if.busy}, 16'd0);
      chk("mul_res_lo", {8'd0, u_if.bus_out}, 16'h0001);
      chk("mul_res_hi", {8'd0, u_if.result_hi}, 16'h00FE);
      chk_flags("mul_flags", 4'b1000);
      n_done = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         if (u_if.done) n_done++;
      end
      chk("mul_single_done", n_done[15:0], 16'd0);

      // Output-enable gate on the bus
      do_op(OP_OR, 8'h50, 8'h0A, 1'b0);
      chk("gate_hi_cleared", {8'd0, u_if.result_hi}, 16'h0000);
      u_if.eo = 1'b0;
      #1;
      chk("gate_eo0", {8'd0, u_if.bus_out}, 16'h0000);
      u_if.eo = 1'b1;
      #1;
      chk("gate_eo1", {8'd0, u_if.bus_out}, 16'h005A);
      u_if.eo = 1'b0;
      @(posedge clk);
      #1;
      u_if.eo = 1'b1;
      #1;
      chk("gate_hold", {8'd0, u_if.bus_out}, 16'h005A);
      chk_flags("gate_flags_hold", 4'b1000);

      // Asynchronous reset in the middle of a multiply
      do_op(OP_MUL, 8'h0F, 8'h0F, 1'b1);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("amid_busy", {15'd0, u_if.busy}, 16'd0);
      chk("amid_done", {15'd0, u_if.done}, 16'd0);
      chk("amid_result", {8'd0, u_if.bus_out}, 16'h0000);
      chk("amid_result_hi", {8'd0, u_if.result_hi}, 16'h0000);
      chk_flags("amid_flags", 4'b0000);
      @(posedge clk);
      #1;
      rst_n  = 1'b1;
      n_done = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (u_if.done || u_if.busy) n_done++;
      end
      chk("amid_no_done", n_done[15:0], 16'd0);
      chk("amid_result_after", {8'd0, u_if.bus_out}, 16'h0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/alu_seq_core.md
Name: alu_seq_core

Overview:
Parametrised, registered ALU core; successor to the fixed 8-bit add/subtract ALU. Accepts an operation via a start/busy/done handshake. Executes single-cycle ops with 1-cycle latency and an iterative shift-add multiply over WIDTH cycles. Holds result and flags (C/Z/N/V) in registers and drives the shared bus only when output is enabled. Instantiated inside the TinyTapeout top wrapper, operands sourced from ui_in/uio_in.

Parameters:
WIDTH, 8, operand/result width in bits (>=4)
CNT_W, $clog2(WIDTH)+1, multiply iteration counter width (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when busy=0
op  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL1, 110 SHR1, 111 MUL
a  input  WIDTH  operand A
b  input  WIDTH  operand B (ignored for SHL1/SHR1)
fi  input  1  flag-load enable, captured with start
eo  input  1  bus output enable
busy  output  1  operation in progress; start ignored while high
done  output  1  one-cycle pulse on the cycle result becomes valid
bus_out  output  WIDTH  result when eo=1, else all zeros (combinational gate of result reg)
result_hi  output  WIDTH  upper product half after MUL; zero after any other op
cf  output  1  carry flag
zf  output  1  zero flag
nf  output  1  negative flag (result MSB)
vf  output  1  signed overflow flag

Behaviour:
- Reset (rst_n=0, async): state IDLE, busy=0, done=0, result=0, result_hi=0, cf=zf=nf=vf=0, counter=0, captured operands=0. Reset mid-MUL aborts; no partial result retained.
- States: IDLE, MUL.
- IDLE, start=1, op!=MUL: at that edge, result/result_hi written, done=1 for the following cycle, state stays IDLE, busy stays 0. Back-to-back starts every cycle allowed; each produces a done pulse.
- IDLE, start=1, op=MUL: capture a, b, fi; clear accumulator; counter=0; state->MUL; busy=1 from next cycle.
- MUL: one shift-add step per edge (LSB-first on multiplier); counter increments; at the WIDTH-th step edge write {result_hi,result}=a*b (unsigned 2*WIDTH), done=1 next cycle, state->IDLE, busy=0 same cycle as done. Latency start->done: WIDTH+1 edges (done visible after edge WIDTH+1... i.e. 9 cycles for WIDTH=8). start during busy ignored, no queuing.
- Arithmetic: ADD r=a+b, cf=carry-out, vf=(a[MSB]==b[MSB])&&(r[MSB]!=a[MSB]). SUB r=a+~b+1, cf=carry-out (1 = no borrow), vf=(a[MSB]!=b[MSB])&&(r[MSB]!=a[MSB]). AND/OR/XOR: cf=0, vf=0. SHL1: r=a<<1, cf=a[MSB], vf=0. SHR1: r=a>>1 logical, cf=a[0], vf=0. MUL: cf=|result_hi, vf=0.
- zf=1 iff result (and result_hi for MUL) all zero; nf=result[MSB].
- Flags update only at the result-write edge, and only if fi was 1 when start was sampled; otherwise flags hold. result/result_hi always update.
- result holds until next completion; bus_out follows eo combinationally without affecting state.

Test Plan:
- Reset: assert rst_n=0 mid-MUL (cycle 3) -> busy=0, done=0, result=0, flags=0 immediately; no done afterwards.
- ADD WIDTH=8: a=0xFF,b=0x01,fi=1,start -> next cycle done=1, result=0x00, cf=1, zf=1, nf=0, vf=0; a=0x7F,b=0x01 -> 0x80, vf=1, nf=1.
- SUB: a=0x05,b=0x03,fi=1 -> 0x02, cf=1; a=0x03,b=0x05 -> 0xFE, cf=0, nf=1; repeat with fi=0 -> result updates, flags unchanged.
- MUL: a=0xFF,b=0xFF,fi=1 -> busy 8 cycles, done once, result=0x01, result_hi=0xFE, cf=1, zf=0; start pulsed while busy with a=0x02 -> ignored.
- Shifts/logic: SHL1 a=0x81 -> 0x02, cf=1; SHR1 a=0x01 -> 0x00, cf=1, zf=1; XOR a=0xAA,b=0xAA -> 0x00, zf=1, cf=0.
- Bus gate: after result=0x5A, eo=0 -> bus_out=0x00; eo=1 -> 0x5A; toggling eo changes no state.
